alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 16, meaning operand and result width.
REQ-002 SHALL have parameter DEPTH, default 4, meaning command FIFO entries (power of 2, at least 2).
REQ-003 SHALL have parameter ALU_LAT, default 1, meaning the ALU's clock cycles from input to registered output (at least 1).
REQ-004 SHALL have port clk, input, 1 bit, meaning the single clock (rising edge).
REQ-005 SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-006 SHALL have ports cmd_valid (input, 1), cmd_ready (output, 1), cmd_fun (input, 4), cmd_a (input, WIDTH) and cmd_b (input, WIDTH), meaning the command handshake.
REQ-007 SHALL have ports alu_a (output, WIDTH), alu_b (output, WIDTH) and alu_fun (output, 4), meaning the drive to the ALU operands and function code.
REQ-008 SHALL have ports alu_out (input, WIDTH), alu_arith_flag, alu_logic_flag, alu_cmp_flag and alu_shift_flag (inputs, 1 each), meaning the ALU result and class flags.
REQ-009 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_data (output, WIDTH) and rsp_flags (output, 4, ordered {arith,logic,cmp,shift}), meaning the response handshake.
REQ-010 SHALL have port busy, output, 1 bit, high when the FSM is not IDLE or the FIFO is non-empty.

Function
REQ-011 SHALL accept a command on the rising edge where cmd_valid and cmd_ready are both high, writing it into the FIFO.
REQ-012 SHALL drive cmd_ready = !fifo_full; a pop in the same cycle does not free a slot for that cycle's push.
REQ-013 SHALL implement FSM states IDLE, WAIT and RESP.
REQ-014 IDLE: if the FIFO is non-empty, SHALL pop the head, register it onto alu_a/alu_b/alu_fun and go to WAIT; otherwise stay in IDLE.
REQ-015 WAIT: SHALL hold alu_* stable for ALU_LAT+1 cycles, capture alu_out and the four flags into rsp_data/rsp_flags on the last WAIT edge, then go to RESP.
REQ-016 RESP: SHALL hold rsp_valid high with stable rsp_data and rsp_flags until rsp_ready is high, then go to IDLE on that edge.
REQ-017 SHALL drive alu_fun = 4'b1111 (NOP) and alu_a = alu_b = 0 in IDLE when no command is popped.
REQ-018 SHALL assert rsp_valid ALU_LAT+2 edges after the accept edge (3 for ALU_LAT=1) when idle with an empty FIFO.
REQ-019 SHALL keep responses in command order, one command in flight, so total capacity is DEPTH+1 commands.
REQ-020 SHALL pass the ALU result unmodified; no width extension or sign handling.
REQ-021 SHALL wrap FIFO pointers modulo DEPTH and distinguish full from empty with an extra pointer bit.

Reset
REQ-022 rst_n low SHALL asynchronously force: FSM to IDLE; FIFO to empty; cmd_ready=1 (after reset); rsp_valid=0; rsp_data=0; rsp_flags=0; alu_a=0; alu_b=0; alu_fun=4'b1111; busy=0; err_count=0.
REQ-023 Reset mid-WAIT or mid-RESP SHALL discard the in-flight command and all queued commands without producing a response.
REQ-024 Reset deassertion SHALL be sampled synchronously; the first command SHALL be accepted on the first edge after release.

Configuration
REQ-025 With macro ALU_SEQ_CHECK_EN defined, SHALL add output err_count (8 bits) and check the captured flags against the class of alu_fun: 0000-0011 arith, 0100-1001 logic, 1010-1100 cmp, 1101-1110 shift, 1111 none.
REQ-026 Under ALU_SEQ_CHECK_EN, on a capture whose flags are not exactly the expected one-hot (or all zero for 1111), SHALL increment err_count, saturating at 255, on the capture edge; rsp_flags SHALL still report the raw flags.
REQ-027 Without ALU_SEQ_CHECK_EN, err_count and the checker SHALL be absent and all other behaviour SHALL be unchanged.

Verification
REQ-028 Scenario: cmd fun=0000, a=1, b=3, rsp_ready=1 -> rsp_valid 3 cycles after accept, rsp_data=4, rsp_flags=4'b1000.
REQ-029 Scenario: rsp_ready=0, push continuously -> exactly 5 commands accepted (DEPTH+1), then cmd_ready=0; raise rsp_ready -> 5 responses in order.
REQ-030 Scenario: fun=1010, a=b=15, rsp_ready=0 for 6 cycles -> rsp_valid held, rsp_data=1 and rsp_flags=4'b0010 stable throughout.
REQ-031 Scenario: rst_n low during WAIT with 2 commands queued -> rsp_valid never asserts, busy=0, cmd_ready=1 after release.
REQ-032 Scenario (ALU_SEQ_CHECK_EN): stub ALU returns logic_flag for fun=0000 -> err_count=1; fun=1111 with flags 0 -> err_count unchanged, rsp_data=0.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Purpose:
//   Queues ALU commands in a small FIFO and issues them one at a time to an
//   external registered ALU. Each command is held on the ALU inputs while the
//   ALU result settles. The result and class flags are then captured and
//   presented as a response. Only one command is in flight at a time, so
//   responses come back in command order.
//
// Parameters:
//   WIDTH   - operand / result width
//   DEPTH   - command FIFO entries (power of 2, >= 2)
//   ALU_LAT - ALU input-to-registered-output latency in cycles (>= 1)
//
// Ports:
//   clk, rst_n                          - clock (rising edge), async active-low reset
//   cmd_valid/cmd_ready                 - command handshake
//   cmd_fun, cmd_a, cmd_b               - command function code and operands
//   alu_a, alu_b, alu_fun               - registered drive to the ALU
//   alu_out, alu_*_flag                 - ALU result and class flags
//   rsp_valid/rsp_ready                 - response handshake
//   rsp_data, rsp_flags                 - captured result, flags {arith,logic,cmp,shift}
//   busy                                - FSM not idle or FIFO non-empty
//   err_count                           - (ALU_SEQ_CHECK_EN only) flag/class mismatch count
//
// Build option:
//   ALU_SEQ_CHECK_EN - adds err_count and a checker that compares captured
//                      flags against the class implied by alu_fun.
// ---------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int WIDTH   = 16,
    parameter int DEPTH   = 4,
    parameter int ALU_LAT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [3:0]       cmd_fun,
    input  logic [WIDTH-1:0] cmd_a,
    input  logic [WIDTH-1:0] cmd_b,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [3:0]       alu_fun,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_arith_flag,
    input  logic             alu_logic_flag,
    input  logic             alu_cmp_flag,
    input  logic             alu_shift_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [WIDTH-1:0] rsp_data,
    output logic [3:0]       rsp_flags,
`ifdef ALU_SEQ_CHECK_EN
    output logic [7:0]       err_count,
`endif
    output logic             busy
);

    localparam int AW    = $clog2(DEPTH);
    localparam int ENT_W = 2 * WIDTH + 4;
    localparam int CNT_W = $clog2(ALU_LAT + 1);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

    localparam logic [3:0]       FUN_NOP  = 4'b1111;
    localparam logic [AW:0]      PTR_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // WAIT spans ALU_LAT+1 cycles; capture happens when the counter hits this.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(ALU_LAT);

    // FIFO storage and pointers (extra MSB separates full from empty)
    logic [ENT_W-1:0] mem_q [DEPTH];
    logic [AW:0]      wr_ptr_q, rd_ptr_q;
    logic             fifo_empty, fifo_full, push, pop;

    // FSM and registered outputs
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] alu_a_q, alu_a_d, alu_b_q, alu_b_d;
    logic [3:0]       alu_fun_q, alu_fun_d;
    logic [WIDTH-1:0] rsp_data_q, rsp_data_d;
    logic [3:0]       rsp_flags_q, rsp_flags_d;
    logic             capture;

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    // cmd_ready depends only on current occupancy, so a same-cycle pop
    // never makes room for a push.
    assign cmd_ready  = !fifo_full;
    assign push       = cmd_valid && cmd_ready;

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= {cmd_fun, cmd_a, cmd_b};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        alu_fun_d   = alu_fun_q;
        rsp_data_d  = rsp_data_q;
        rsp_flags_d = rsp_flags_q;
        pop         = 1'b0;
        capture     = 1'b0;
        case (state_q)
            S_IDLE: begin
                alu_a_d   = '0;
                alu_b_d   = '0;
                alu_fun_d = FUN_NOP;
                if (!fifo_empty) begin
                    pop = 1'b1;
                    {alu_fun_d, alu_a_d, alu_b_d} = mem_q[rd_ptr_q[AW-1:0]];
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (cnt_q == CNT_LAST) begin
                    capture     = 1'b1;
                    rsp_data_d  = alu_out;
                    rsp_flags_d = {alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag};
                    // Operands are no longer needed; park the ALU on NOP.
                    alu_a_d     = '0;
                    alu_b_d     = '0;
                    alu_fun_d   = FUN_NOP;
                    state_d     = S_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end
            S_RESP: begin
                if (rsp_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            alu_fun_q   <= FUN_NOP;
            rsp_data_q  <= '0;
            rsp_flags_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            alu_fun_q   <= alu_fun_d;
            rsp_data_q  <= rsp_data_d;
            rsp_flags_q <= rsp_flags_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_fun   = alu_fun_q;
    assign rsp_valid = (state_q == S_RESP);
    assign rsp_data  = rsp_data_q;
    assign rsp_flags = rsp_flags_q;
    assign busy      = (state_q != S_IDLE) || !fifo_empty;

`ifdef ALU_SEQ_CHECK_EN
    // Expected one-hot flag pattern {arith,logic,cmp,shift} for a function code.
    function automatic logic [3:0] class_flags(input logic [3:0] fun);
        if (fun <= 4'b0011)      class_flags = 4'b1000;
        else if (fun <= 4'b1001) class_flags = 4'b0100;
        else if (fun <= 4'b1100) class_flags = 4'b0010;
        else if (fun <= 4'b1110) class_flags = 4'b0001;
        else                     class_flags = 4'b0000;
    endfunction

    logic [7:0] err_count_q;

    // alu_fun_q still holds the issued command on the capture edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_count_q <= '0;
        end else if (capture && (rsp_flags_d != class_flags(alu_fun_q)) && (err_count_q != 8'hFF)) begin
            err_count_q <= err_count_q + 8'd1;
        end
    end

    assign err_count = err_count_q;
`endif

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// ---------------------------------------------------------------------------
// tb_alu_cmd_sequencer
//
// Directed bench for alu_cmd_sequencer (WIDTH=16, DEPTH=4, ALU_LAT=1). A
// small registered stub ALU sits behind the sequencer; expected results are
// hand-computed constants.
// ---------------------------------------------------------------------------
module tb_alu_cmd_sequencer;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [3:0]       cmd_fun;
    logic [WIDTH-1:0] cmd_a, cmd_b;
    logic [WIDTH-1:0] alu_a, alu_b;
    logic [3:0]       alu_fun;
    logic [WIDTH-1:0] alu_out;
    logic             alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [WIDTH-1:0] rsp_data;
    logic [3:0]       rsp_flags;
    logic             busy;
`ifdef ALU_SEQ_CHECK_EN
    logic [7:0]       err_count;
`endif

    int total  = 0;
    int passed = 0;

    alu_cmd_sequencer #(.WIDTH(WIDTH), .DEPTH(4), .ALU_LAT(1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_fun        (cmd_fun),
        .cmd_a          (cmd_a),
        .cmd_b          (cmd_b),
        .alu_a          (alu_a),
        .alu_b          (alu_b),
        .alu_fun        (alu_fun),
        .alu_out        (alu_out),
        .alu_arith_flag (alu_arith_flag),
        .alu_logic_flag (alu_logic_flag),
        .alu_cmp_flag   (alu_cmp_flag),
        .alu_shift_flag (alu_shift_flag),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_flags      (rsp_flags),
`ifdef ALU_SEQ_CHECK_EN
        .err_count      (err_count),
`endif
        .busy           (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stub ALU, one registered stage. 'corrupt' forces a wrong flag pattern.
    logic             corrupt;
    logic [WIDTH-1:0] stub_res;
    logic [3:0]       stub_fl;

    always_comb begin
        stub_res = '0;
        case (alu_fun)
            4'b0000: stub_res = alu_a + alu_b;
            4'b0001: stub_res = alu_a - alu_b;
            4'b0100: stub_res = alu_a & alu_b;
            4'b0101: stub_res = alu_a | alu_b;
            4'b0110: stub_res = alu_a ^ alu_b;
            4'b1010: stub_res = (alu_a == alu_b) ? 16'd1 : 16'd0;
            4'b1011: stub_res = (alu_a < alu_b) ? 16'd1 : 16'd0;
            4'b1101: stub_res = alu_a << alu_b[3:0];
            4'b1110: stub_res = alu_a >> alu_b[3:0];
            default: stub_res = '0;
        endcase
        if (alu_fun <= 4'b0011)      stub_fl = 4'b1000;
        else if (alu_fun <= 4'b1001) stub_fl = 4'b0100;
        else if (alu_fun <= 4'b1100) stub_fl = 4'b0010;
        else if (alu_fun <= 4'b1110) stub_fl = 4'b0001;
        else                         stub_fl = 4'b0000;
        if (corrupt) stub_fl = 4'b0100;
    end

    always_ff @(posedge clk) begin
        alu_out <= stub_res;
        {alu_arith_flag, alu_logic_flag, alu_cmp_flag, alu_shift_flag} <= stub_fl;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drain table for the back-pressure scenario
    logic [3:0]       t_fun  [5];
    logic [WIDTH-1:0] t_a    [5];
    logic [WIDTH-1:0] t_b    [5];
    logic [WIDTH-1:0] t_data [5];
    logic [3:0]       t_fl   [5];

    initial begin
        int n_acc;
        int w;
        logic acc;
        logic seen;

        t_fun[0] = 4'b0000; t_a[0] = 16'h0010; t_b[0] = 16'h0005; t_data[0] = 16'h0015; t_fl[0] = 4'b1000;
        t_fun[1] = 4'b0001; t_a[1] = 16'h0005; t_b[1] = 16'h0010; t_data[1] = 16'hFFF5; t_fl[1] = 4'b1000;
        t_fun[2] = 4'b0100; t_a[2] = 16'h00F0; t_b[2] = 16'h0F3C; t_data[2] = 16'h0030; t_fl[2] = 4'b0100;
        t_fun[3] = 4'b1011; t_a[3] = 16'h0003; t_b[3] = 16'h0007; t_data[3] = 16'h0001; t_fl[3] = 4'b0010;
        t_fun[4] = 4'b1101; t_a[4] = 16'h0001; t_b[4] = 16'h0004; t_data[4] = 16'h0010; t_fl[4] = 4'b0001;

        corrupt   = 1'b0;
        cmd_valid = 1'b0;
        cmd_fun   = 4'b0000;
        cmd_a     = '0;
        cmd_b     = '0;
        rsp_ready = 1'b0;
        rst_n     = 1'b1;
        #2 rst_n  = 1'b0;
        #20;

        // Reset state
        check("rst cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst rsp_data",  32'(rsp_data),  32'd0);
        check("rst rsp_flags", 32'(rsp_flags), 32'd0);
        check("rst alu_a",     32'(alu_a),     32'd0);
        check("rst alu_b",     32'(alu_b),     32'd0);
        check("rst alu_fun",   32'(alu_fun),   32'hF);
        check("rst busy",      32'(busy),      32'd0);
`ifdef ALU_SEQ_CHECK_EN
        check("rst err_count", 32'(err_count), 32'd0);
`endif
        tick();
        rst_n = 1'b1;

        // Single add: 1 + 3, response three edges after accept
        rsp_ready = 1'b1;
        cmd_valid = 1'b1; cmd_fun = 4'b0000; cmd_a = 16'd1; cmd_b = 16'd3;
        tick();
        cmd_valid = 1'b0;
        check("add busy after accept", 32'(busy), 32'd1);
        check("add rsp_valid +1",      32'(rsp_valid), 32'd0);
        tick();
        check("add alu_a issued",   32'(alu_a),   32'd1);
        check("add alu_b issued",   32'(alu_b),   32'd3);
        check("add alu_fun issued", 32'(alu_fun), 32'd0);
        tick();
        check("add alu_a held",   32'(alu_a), 32'd1);
        check("add rsp_valid +2", 32'(rsp_valid), 32'd0);
        tick();
        check("add rsp_valid +3", 32'(rsp_valid), 32'd1);
        check("add rsp_data",     32'(rsp_data),  32'd4);
        check("add rsp_flags",    32'(rsp_flags), 32'b1000);
        check("add alu_fun nop",  32'(alu_fun),   32'hF);
        tick();
        check("add rsp_valid done", 32'(rsp_valid), 32'd0);
        check("add busy done",      32'(busy),      32'd0);

        // Compare 15 == 15 with response held off for 6 cycles
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_fun = 4'b1010; cmd_a = 16'd15; cmd_b = 16'd15;
        tick();
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        for (int i = 0; i < 6; i++) begin
            check("cmp rsp_valid held", 32'(rsp_valid), 32'd1);
            check("cmp rsp_data held",  32'(rsp_data),  32'd1);
            check("cmp rsp_flags held", 32'(rsp_flags), 32'b0010);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        check("cmp rsp_valid released", 32'(rsp_valid), 32'd0);

        // Back-pressure: capacity is DEPTH+1, then drain in order
        rsp_ready = 1'b0;
        n_acc = 0;
        for (int c = 0; c < 10; c++) begin
            cmd_valid = 1'b1;
            if (n_acc < 5) begin
                cmd_fun = t_fun[n_acc]; cmd_a = t_a[n_acc]; cmd_b = t_b[n_acc];
            end else begin
                cmd_fun = 4'b0110; cmd_a = 16'hDEAD; cmd_b = 16'hBEEF;
            end
            acc = cmd_ready;
            tick();
            if (acc) n_acc++;
        end
        cmd_valid = 1'b0;
        check("bp accepted count", 32'(n_acc),     32'd5);
        check("bp cmd_ready full", 32'(cmd_ready), 32'd0);
        check("bp busy",           32'(busy),      32'd1);
        rsp_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            w = 0;
            while (!rsp_valid && w < 10) begin
                tick();
                w++;
            end
            check("bp rsp_valid", 32'(rsp_valid), 32'd1);
            check("bp rsp_data",  32'(rsp_data),  32'(t_data[k]));
            check("bp rsp_flags", 32'(rsp_flags), 32'(t_fl[k]));
            tick();
        end
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            seen = seen | rsp_valid;
            tick();
        end
        check("bp no extra rsp", 32'(seen), 32'd0);
        check("bp busy drained", 32'(busy), 32'd0);

        // Reset mid-WAIT with two commands queued
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_fun = 4'b0000; cmd_a = 16'd1; cmd_b = 16'd1;
        tick();
        cmd_a = 16'd2;
        tick();
        cmd_a = 16'd3;
        tick();
        cmd_valid = 1'b0;
        check("mid busy before rst", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid rst busy",      32'(busy),      32'd0);
        check("mid rst rsp_valid", 32'(rsp_valid), 32'd0);
        check("mid rst alu_fun",   32'(alu_fun),   32'hF);
        tick(); tick();
        rst_n = 1'b1;
        rsp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            seen = seen | rsp_valid;
            tick();
        end
        check("mid no rsp after rst", 32'(seen),      32'd0);
        check("mid busy after rst",   32'(busy),      32'd0);
        check("mid cmd_ready",        32'(cmd_ready), 32'd1);

        // First edge after release accepts; FFFF + 1 wraps to 0 unmodified
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        cmd_valid = 1'b1; cmd_fun = 4'b0000; cmd_a = 16'hFFFF; cmd_b = 16'h0001;
        tick();
        cmd_valid = 1'b0;
        check("rel accepted busy", 32'(busy), 32'd1);
        tick(); tick();
        check("rel rsp_valid +2", 32'(rsp_valid), 32'd0);
        tick();
        check("rel rsp_valid +3", 32'(rsp_valid), 32'd1);
        check("rel wrap data",    32'(rsp_data),  32'd0);
        check("rel wrap flags",   32'(rsp_flags), 32'b1000);
        tick();

`ifdef ALU_SEQ_CHECK_EN
        // Wrong class flag for an arith op, then a clean NOP
        check("chk err before", 32'(err_count), 32'd0);
        corrupt = 1'b1;
        cmd_valid = 1'b1; cmd_fun = 4'b0000; cmd_a = 16'd2; cmd_b = 16'd2;
        tick();
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        check("chk err bad flags", 32'(err_count), 32'd1);
        check("chk raw flags",     32'(rsp_flags), 32'b0100);
        tick();
        corrupt = 1'b0;
        cmd_valid = 1'b1; cmd_fun = 4'b1111; cmd_a = 16'd9; cmd_b = 16'd9;
        tick();
        cmd_valid = 1'b0;
        tick(); tick(); tick();
        check("chk nop rsp_valid", 32'(rsp_valid), 32'd1);
        check("chk nop data",      32'(rsp_data),  32'd0);
        check("chk nop err",       32'(err_count), 32'd1);
        tick();
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
